// File: rtl/wb_stim_sequencer.sv
// Wishbone stimulus sequencer: answers a core's Wishbone requests from two
// pushed stimulus FIFOs (instructions and load data), injects load data a
// fixed number of read beats after a load instruction, and captures stores.

// Small synchronous FIFO used for both stimulus streams.
module StimFifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  logic [31:0] pushData_i,
  input  logic        pop_i,
  output logic [31:0] head_o,
  output logic        empty_o,
  output logic        full_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q;
  logic [AW-1:0] rdPtr_q;
  logic [AW:0]   count_q;
  logic          doPush;
  logic          doPop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rdPtr_q];
  assign doPush  = push_i & ~full_o;
  assign doPop   = pop_i & ~empty_o;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= pushData_i;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
      count_q <= count_q + (AW+1)'(doPush) - (AW+1)'(doPop);
    end
  end
endmodule

module wb_stim_sequencer #(
  parameter int LOAD_DELAY  = 3,
  parameter int WAIT_STATES = 0,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_valid,
  input  logic [31:0] inst_data,
  output logic        inst_ready,
  input  logic        data_valid,
  input  logic [31:0] data_in,
  output logic        data_ready,
  input  logic [31:0] o_wb_adr,
  input  logic [3:0]  o_wb_sel,
  input  logic        o_wb_we,
  input  logic [31:0] o_wb_dat,
  input  logic        o_wb_cyc,
  input  logic        o_wb_stb,
  output logic [31:0] i_wb_dat,
  output logic        i_wb_ack,
  output logic        i_wb_err,
  output logic        wr_valid,
  output logic [31:0] wr_adr,
  output logic [31:0] wr_dat,
  output logic [3:0]  wr_sel,
  output logic        underflow
);
  localparam int LCW = $clog2(LOAD_DELAY + 1) + 1;
  localparam int WCW = $clog2(WAIT_STATES + 1) + 1;
  localparam logic [31:0] NOP_INSN  = 32'hE1A0_0000;
  localparam logic [31:0] LOAD_MASK = 32'hFDB8_8000;
  localparam logic [31:0] LOAD_PAT  = 32'hE590_0000;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t         state_q, state_d;
  logic [WCW-1:0] waitCnt_q, waitCnt_d;
  logic           ldPending_q, ldPending_d;
  logic [LCW-1:0] ldCnt_q, ldCnt_d;
  logic           underflow_q, underflow_d;
  logic [31:0]    datHold_q, datHold_d;
  logic [31:0]    adr_q, adr_d;
  logic [31:0]    dat_q, dat_d;
  logic [3:0]     sel_q, sel_d;
  logic           we_q, we_d;
  logic           alive_q;

  logic        req;
  logic        popInst, popData;
  logic        instEmpty, instFull, dataEmpty, dataFull;
  logic [31:0] instHead, dataHead, respData;
  logic        ackComb, errComb, wrValidComb;

  assign req        = o_wb_cyc & o_wb_stb;
  assign inst_ready = alive_q & ~instFull;
  assign data_ready = alive_q & ~dataFull;

  StimFifo #(.DEPTH(FIFO_DEPTH)) instFifo (
    .clk(clk), .rst_n(rst_n),
    .push_i(inst_valid & inst_ready), .pushData_i(inst_data),
    .pop_i(popInst), .head_o(instHead), .empty_o(instEmpty), .full_o(instFull)
  );

  StimFifo #(.DEPTH(FIFO_DEPTH)) dataFifo (
    .clk(clk), .rst_n(rst_n),
    .push_i(data_valid & data_ready), .pushData_i(data_in),
    .pop_i(popData), .head_o(dataHead), .empty_o(dataEmpty), .full_o(dataFull)
  );

  // Beat sequencing, response selection and load-injection bookkeeping.
  always_comb begin
    state_d     = state_q;
    waitCnt_d   = waitCnt_q;
    ldPending_d = ldPending_q;
    ldCnt_d     = ldCnt_q;
    underflow_d = underflow_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    we_d        = we_q;
    popInst     = 1'b0;
    popData     = 1'b0;
    respData    = datHold_q;
    ackComb     = 1'b0;
    errComb     = 1'b0;
    wrValidComb = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          adr_d = o_wb_adr;
          dat_d = o_wb_dat;
          sel_d = o_wb_sel;
          we_d  = o_wb_we;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            state_d   = WAIT;
            waitCnt_d = WCW'(WAIT_STATES);
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_d   = IDLE;
          waitCnt_d = '0;
        end else if (waitCnt_q <= WCW'(1)) begin
          state_d   = RESP;
          waitCnt_d = '0;
        end else begin
          waitCnt_d = waitCnt_q - WCW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        if (adr_q[1:0] != 2'b00) begin
          errComb = 1'b1;
        end else if (we_q) begin
          ackComb     = 1'b1;
          wrValidComb = 1'b1;
        end else begin
          ackComb = 1'b1;
          if (ldPending_q && (ldCnt_q == LCW'(LOAD_DELAY))) begin
            ldPending_d = 1'b0;
            ldCnt_d     = '0;
            if (!dataEmpty) begin
              respData = dataHead;
              popData  = 1'b1;
            end else begin
              respData    = 32'h0000_0000;
              underflow_d = 1'b1;
            end
          end else begin
            if (ldPending_q) ldCnt_d = ldCnt_q + LCW'(1);
            if (!instEmpty) begin
              respData = instHead;
              popInst  = 1'b1;
              if ((instHead & LOAD_MASK) == LOAD_PAT) begin
                ldPending_d = 1'b1;
                ldCnt_d     = '0;
              end
            end else begin
              respData    = NOP_INSN;
              underflow_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    datHold_d = respData;
  end

  // State register; reset aborts any beat in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      waitCnt_q   <= '0;
      ldPending_q <= 1'b0;
      ldCnt_q     <= '0;
      underflow_q <= 1'b0;
      datHold_q   <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      alive_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      waitCnt_q   <= waitCnt_d;
      ldPending_q <= ldPending_d;
      ldCnt_q     <= ldCnt_d;
      underflow_q <= underflow_d;
      datHold_q   <= datHold_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      alive_q     <= 1'b1;
    end
  end

  assign i_wb_dat  = respData;
  assign i_wb_ack  = ackComb;
  assign i_wb_err  = errComb;
  assign wr_valid  = wrValidComb;
  assign wr_adr    = adr_q;
  assign wr_dat    = dat_q;
  assign wr_sel    = sel_q;
  assign underflow = underflow_q;
endmodule

// File: tb/tb_wb_stim_sequencer.sv
// Directed testbench for wb_stim_sequencer: one instance with default
// parameters, a second with two wait states for the mid-beat reset case.
module tb_wb_stim_sequencer;
  logic        clk;
  logic        rst_n, rst2_n;
  logic        instValid, instValid2, dataValid;
  logic [31:0] instData, dataIn;
  logic [31:0] wbAdr, wbDat;
  logic [3:0]  wbSel;
  logic        wbWe;
  logic        cyc1, stb1, cyc2, stb2;

  logic        instReady, dataReady, ack, err, wrValid, underflow;
  logic [31:0] rdDat, wrAdr, wrDat;
  logic [3:0]  wrSel;
  logic        instReady2, dataReady2, ack2, err2, wrValid2, underflow2;
  logic [31:0] rdDat2, wrAdr2, wrDat2;
  logic [3:0]  wrSel2;

  int compared;
  int mismatched;

  logic [31:0] obsDat, obsWrAdr, obsWrDat;
  logic [3:0]  obsWrSel;
  logic        obsAck, obsErr, obsWrv;
  int          obsLat;
  logic        sawAck;

  logic [31:0] exp29 [3] = '{32'hE1A00000, 32'hE3A01001, 32'hE3A02002};
  logic [31:0] exp30 [5] = '{32'hE5912000, 32'hE1A00000, 32'hE1A00000,
                             32'hE1A00000, 32'hDEADBEEF};
  logic [31:0] expRs [6] = '{32'hE5912000, 32'hE5912000, 32'hE1A00000,
                             32'hE1A00000, 32'hE1A00000, 32'hCAFEF00D};

  wb_stim_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .inst_valid(instValid), .inst_data(instData), .inst_ready(instReady),
    .data_valid(dataValid), .data_in(dataIn), .data_ready(dataReady),
    .o_wb_adr(wbAdr), .o_wb_sel(wbSel), .o_wb_we(wbWe), .o_wb_dat(wbDat),
    .o_wb_cyc(cyc1), .o_wb_stb(stb1),
    .i_wb_dat(rdDat), .i_wb_ack(ack), .i_wb_err(err),
    .wr_valid(wrValid), .wr_adr(wrAdr), .wr_dat(wrDat), .wr_sel(wrSel),
    .underflow(underflow)
  );

  wb_stim_sequencer #(.LOAD_DELAY(3), .WAIT_STATES(2), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst_n(rst2_n),
    .inst_valid(instValid2), .inst_data(instData), .inst_ready(instReady2),
    .data_valid(1'b0), .data_in(dataIn), .data_ready(dataReady2),
    .o_wb_adr(wbAdr), .o_wb_sel(wbSel), .o_wb_we(wbWe), .o_wb_dat(wbDat),
    .o_wb_cyc(cyc2), .o_wb_stb(stb2),
    .i_wb_dat(rdDat2), .i_wb_ack(ack2), .i_wb_err(err2),
    .wr_valid(wrValid2), .wr_adr(wrAdr2), .wr_dat(wrDat2), .wr_sel(wrSel2),
    .underflow(underflow2)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and record it.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%08h required 0x%08h", tag, got, exp);
    end
  endtask

  // Push one instruction word into the chosen instance.
  task automatic pushInst(input int which, input logic [31:0] v);
    instData = v;
    if (which == 1) instValid = 1'b1; else instValid2 = 1'b1;
    @(posedge clk); #1;
    instValid  = 1'b0;
    instValid2 = 1'b0;
  endtask

  // Push one load-data word into the default instance.
  task automatic pushData(input logic [31:0] v);
    dataIn    = v;
    dataValid = 1'b1;
    @(posedge clk); #1;
    dataValid = 1'b0;
  endtask

  // Run one bounded Wishbone beat and capture the response cycle.
  task automatic applyStimulus(input int which, input logic we, input logic [31:0] adr,
                               input logic [31:0] dat, input logic [3:0] sel);
    logic seen;
    wbWe = we; wbAdr = adr; wbDat = dat; wbSel = sel;
    if (which == 1) begin cyc1 = 1'b1; stb1 = 1'b1; end
    else begin cyc2 = 1'b1; stb2 = 1'b1; end
    obsLat = 0; obsAck = 1'b0; obsErr = 1'b0; obsWrv = 1'b0; obsDat = '0;
    seen = 1'b0;
    while (!seen && obsLat < 20) begin
      @(posedge clk); #1;
      obsLat++;
      if (which == 1 ? (ack | err) : (ack2 | err2)) begin
        seen     = 1'b1;
        obsAck   = (which == 1) ? ack : ack2;
        obsErr   = (which == 1) ? err : err2;
        obsDat   = (which == 1) ? rdDat : rdDat2;
        obsWrv   = (which == 1) ? wrValid : wrValid2;
        obsWrAdr = wrAdr; obsWrDat = wrDat; obsWrSel = wrSel;
      end
    end
    cyc1 = 1'b0; stb1 = 1'b0; cyc2 = 1'b0; stb2 = 1'b0;
    @(posedge clk); #1;
  endtask

  // Last-resort guard so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence.
  initial begin
    compared = 0; mismatched = 0;
    rst_n = 1'b0; rst2_n = 1'b0;
    instValid = 0; instValid2 = 0; dataValid = 0;
    instData = '0; dataIn = '0; wbAdr = '0; wbDat = '0; wbSel = '0; wbWe = 0;
    cyc1 = 0; stb1 = 0; cyc2 = 0; stb2 = 0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstInstReady", instReady, 0);
    checkOutput("rstDataReady", dataReady, 0);
    checkOutput("rstDat", rdDat, 0);
    checkOutput("rstAck", ack, 0);
    checkOutput("rstErr", err, 0);
    checkOutput("rstWrValid", wrValid, 0);
    checkOutput("rstWrAdr", wrAdr, 0);
    checkOutput("rstUnderflow", underflow, 0);
    rst_n = 1'b1; rst2_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("relInstReady", instReady, 1);
    checkOutput("relDataReady", dataReady, 1);

    // Plain instruction stream in push order.
    for (int i = 0; i < 3; i++) pushInst(1, exp29[i]);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1'b0, 32'h0, 32'h0, 4'hF);
      checkOutput($sformatf("r29Dat%0d", i), obsDat, exp29[i]);
      checkOutput($sformatf("r29Lat%0d", i), obsLat, 1);
      checkOutput($sformatf("r29Ack%0d", i), obsAck, 1);
    end
    checkOutput("ackDropped", ack, 0);

    // Load followed by delay beats, then the data beat.
    pushInst(1, 32'hE5912000);
    pushInst(1, 32'hE1A00000);
    pushInst(1, 32'hE1A00000);
    checkOutput("readyBeforeFull", instReady, 1);
    pushInst(1, 32'hE1A00000);
    checkOutput("readyWhenFull", instReady, 0);
    pushData(32'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1'b0, 32'h0, 32'h0, 4'hF);
      checkOutput($sformatf("r30Dat%0d", i), obsDat, exp30[i]);
    end
    pushInst(1, 32'hE3A01001);
    applyStimulus(1, 1'b0, 32'h4, 32'h0, 4'hF);
    checkOutput("ldPendCleared", obsDat, 32'hE3A01001);
    checkOutput("noUnderflowYet", underflow, 0);

    // Store capture; instruction FIFO untouched.
    pushInst(1, 32'hE3A02002);
    applyStimulus(1, 1'b1, 32'h100, 32'h12345678, 4'hF);
    checkOutput("wrAck", obsAck, 1);
    checkOutput("wrValid", obsWrv, 1);
    checkOutput("wrAdr", obsWrAdr, 32'h100);
    checkOutput("wrDat", obsWrDat, 32'h12345678);
    checkOutput("wrSel", obsWrSel, 4'hF);
    checkOutput("wrValidDrop", wrValid, 0);
    applyStimulus(1, 1'b0, 32'h0, 32'h0, 4'hF);
    checkOutput("afterWrite", obsDat, 32'hE3A02002);

    // Misaligned access answers with error and pops nothing.
    pushInst(1, 32'hE1A01001);
    applyStimulus(1, 1'b0, 32'h102, 32'h0, 4'hF);
    checkOutput("misErr", obsErr, 1);
    checkOutput("misAck", obsAck, 0);
    checkOutput("misLat", obsLat, 1);
    checkOutput("errDropped", err, 0);
    applyStimulus(1, 1'b0, 32'h0, 32'h0, 4'hF);
    checkOutput("noPopOnErr", obsDat, 32'hE1A01001);
    checkOutput("noUnderflowErr", underflow, 0);

    // Empty FIFO read gives the filler and a sticky underflow.
    applyStimulus(1, 1'b0, 32'h0, 32'h0, 4'hF);
    checkOutput("emptyDat", obsDat, 32'hE1A00000);
    checkOutput("underflowSet", underflow, 1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("underflowHeld", underflow, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("underflowRst", underflow, 0);
    checkOutput("datRst", rdDat, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // A second load among the delay beats restarts the count.
    pushInst(1, 32'hE5912000);
    pushInst(1, 32'hE5912000);
    pushInst(1, 32'hE1A00000);
    pushInst(1, 32'hE1A00000);
    pushData(32'hCAFEF00D);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 1'b0, 32'h0, 32'h0, 4'hF);
      checkOutput($sformatf("restartDat%0d", i), obsDat, expRs[i]);
    end

    // Reset during a wait state on the two-wait-state instance.
    pushInst(2, 32'hE3A0F00F);
    wbWe = 1'b0; wbAdr = 32'h40; wbDat = '0; wbSel = 4'hF;
    cyc2 = 1'b1; stb2 = 1'b1;
    @(posedge clk); #1;
    checkOutput("waitNoAck", ack2, 0);
    rst2_n = 1'b0;
    #1;
    checkOutput("midRstAck", ack2, 0);
    checkOutput("midRstErr", err2, 0);
    checkOutput("midRstDat", rdDat2, 0);
    checkOutput("midRstWrValid", wrValid2, 0);
    checkOutput("midRstWrAdr", wrAdr2, 0);
    checkOutput("midRstReady", instReady2, 0);
    cyc2 = 1'b0; stb2 = 1'b0;
    @(posedge clk); #1;
    rst2_n = 1'b1;
    sawAck = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      sawAck = sawAck | ack2 | err2 | wrValid2;
    end
    checkOutput("noRespAfterRst", sawAck, 0);
    applyStimulus(2, 1'b0, 32'h0, 32'h0, 4'hF);
    checkOutput("ws2Lat", obsLat, 3);
    checkOutput("ws2FifoEmpty", obsDat, 32'hE1A00000);
    checkOutput("ws2Underflow", underflow2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/wb_stim_sequencer.md
WB_STIM_SEQUENCER -- requirements
Module: wb_stim_sequencer

Interface
REQ-001 Parameter LOAD_DELAY, default 3, meaning: read beats served from the instruction FIFO after a detected load and before its data beat.
REQ-002 Parameter WAIT_STATES, default 0, meaning: extra cycles between request detection and ack/err.
REQ-003 Parameter FIFO_DEPTH, default 4, meaning: entries in each stimulus FIFO (power of 2, >=2).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 inst_valid / inst_data / inst_ready  in / in / out  1 / 32 / 1  instruction push handshake.
REQ-007 data_valid / data_in / data_ready  in / in / out  1 / 32 / 1  load-data push handshake.
REQ-008 o_wb_adr, o_wb_sel, o_wb_we, o_wb_dat, o_wb_cyc, o_wb_stb  input  32,4,1,32,1,1  core Wishbone master outputs.
REQ-009 i_wb_dat, i_wb_ack, i_wb_err  output  32,1,1  Wishbone slave response to core.
REQ-010 wr_valid, wr_adr, wr_dat, wr_sel  output  1,32,32,4  captured store beat.
REQ-011 underflow  output  1  sticky flag: a read beat found its FIFO empty.

Function
REQ-012 Request = o_wb_cyc & o_wb_stb; FSM states IDLE, WAIT, RESP.
REQ-013 IDLE + request: WAIT_STATES=0 -> RESP next cycle; else WAIT, counter loaded with WAIT_STATES, RESP after counter reaches 0.
REQ-014 WAIT + request deasserted: return to IDLE; no pop, no ack, no capture.
REQ-015 RESP lasts exactly one cycle: i_wb_ack=1 (or i_wb_err=1); then IDLE unconditionally; minimum one idle cycle between beats.
REQ-016 o_wb_adr[1:0] != 0: i_wb_err=1, i_wb_ack=0, no pop, no capture, load counter unchanged.
REQ-017 Read beat (o_wb_we=0) with no load pending: i_wb_dat = inst FIFO head, popped at end of RESP cycle.
REQ-018 Popped instruction is a load when (inst & 0xFDB8_8000) == 0xE590_0000; sets ld_pending, ld_cnt=0.
REQ-019 With ld_pending: while ld_cnt < LOAD_DELAY read beats serve inst FIFO and increment ld_cnt; at ld_cnt == LOAD_DELAY beat serves data FIFO head (popped) and clears ld_pending.
REQ-020 Load detected while ld_pending (among delay beats): restart, ld_cnt=0.
REQ-021 Empty FIFO at read beat: i_wb_dat = 0xE1A0_0000 (inst) or 0x0000_0000 (data); no pop; underflow=1 until reset; load sequencing still advances.
REQ-022 Write beat (o_wb_we=1): ack; wr_valid=1 for the RESP cycle only with wr_adr/wr_dat/wr_sel = o_wb_adr/o_wb_dat/o_wb_sel sampled at request; no pop; ld_cnt unchanged.
REQ-023 i_wb_dat holds last driven value outside RESP.
REQ-024 FIFOs: ready = not full; push on valid & ready; simultaneous push and pop allowed when not full; order preserved; pointers wrap modulo FIFO_DEPTH.
REQ-025 Request address/we/sel/dat latched in IDLE; later changes during WAIT ignored.

Reset
REQ-026 rst_n low asynchronously: FSM=IDLE, both FIFOs empty, ld_pending=0, ld_cnt=0, wait counter=0, underflow=0.
REQ-027 Reset outputs: i_wb_dat=0, i_wb_ack=0, i_wb_err=0, wr_valid=0, wr_adr=0, wr_dat=0, wr_sel=0, inst_ready=0 and data_ready=0 while rst_n low, 1 from first cycle after release.
REQ-028 Reset mid-beat (WAIT or RESP) aborts it; no ack/err/wr_valid after release until a new request.

Verification
REQ-029 Push 0xE1A00000, 0xE3A01001, 0xE3A02002; three reads, WAIT_STATES=0 -> ack one cycle after each request, i_wb_dat in push order, inst FIFO empty after.
REQ-030 Push 0xE5912000, three 0xE1A00000, data 0xDEADBEEF; five reads -> beats 2-4 = 0xE1A00000, beat 5 = 0xDEADBEEF, ld_pending cleared.
REQ-031 Write adr 0x100, dat 0x12345678, sel 0xF -> wr_valid one cycle with those values; inst FIFO count unchanged.
REQ-032 Read with empty inst FIFO -> i_wb_dat=0xE1A00000, underflow=1, held until rst_n low.
REQ-033 Read at adr 0x102 -> i_wb_err=1 one cycle, i_wb_ack=0, no pop.
REQ-034 WAIT_STATES=2, rst_n low during WAIT -> all outputs 0 immediately, FIFOs empty, no ack after release.
